mem_port_arbiter: RTL and testbench



---
 rtl/mem_port_arbiter.sv | 128 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter/sequencer for the single-ported 16-bit main memory (fetch = port 0, load/store = port 1).
// Latency: write 2 cycles, read RD_LATENCY+2 cycles from req sampled to done; one access in flight at a time.
// Backpressure: req is sampled only in IDLE; a losing or blocked port keeps req high and is served next by the last pointer.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 9,
    parameter int RD_LATENCY = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [15:0]           m0_wdata,
    output logic                  m0_gnt,
    output logic                  m0_done,
    output logic [15:0]           m0_rdata,
    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [15:0]           m1_wdata,
    output logic                  m1_gnt,
    output logic                  m1_done,
    output logic [15:0]           m1_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [15:0]           mem_wdata,
    output logic                  mem_load,
    input  logic [15:0]           mem_rdata,
    output logic                  busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    // Read wait is counted in a 3-bit counter, enough for latencies 0..7.
    localparam logic [2:0] RD_LAT = RD_LATENCY[2:0];

    state_t     state;
    state_t     state_nxt;
    logic       owner;      // port currently being served
    logic       last;       // port granted most recently; the other one wins a tie
    logic       we_q;       // captured direction of the access in flight
    logic [2:0] cnt;        // read wait counter
    logic       req_any;
    logic       winner;
    logic       rd_hit;

    assign req_any = m0_req | m1_req;
    // Single requester wins outright; on a tie the port that did not go last wins.
    assign winner  = (m0_req & m1_req) ? ~last : m1_req;
    assign rd_hit  = (cnt == RD_LAT);

    // State register; reset abandons any access in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: accept in IDLE, leave ACCESS after the write cycle or once read data is due.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (req_any) state_nxt = S_ACCESS;
            S_ACCESS: if (we_q || rd_hit) state_nxt = S_DONE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Completion pulses and busy decode straight from state, so reset clears them immediately.
    always_comb begin
        m0_done = (state == S_DONE) && !owner;
        m1_done = (state == S_DONE) && owner;
        busy    = (state != S_IDLE);
    end

    // Accept-edge capture of the winner's request; grant and load strobe are single-cycle pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner     <= 1'b0;
            last      <= 1'b1;
            we_q      <= 1'b0;
            cnt       <= 3'd0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_load  <= 1'b0;
            m0_gnt    <= 1'b0;
            m1_gnt    <= 1'b0;
        end else begin
            m0_gnt   <= 1'b0;
            m1_gnt   <= 1'b0;
            mem_load <= 1'b0;
            if (state == S_IDLE && req_any) begin
                owner     <= winner;
                last      <= winner;
                we_q      <= winner ? m1_we : m0_we;
                mem_addr  <= winner ? m1_addr : m0_addr;
                mem_wdata <= winner ? m1_wdata : m0_wdata;
                mem_load  <= winner ? m1_we : m0_we;
                cnt       <= 3'd0;
                m0_gnt    <= !winner;
                m1_gnt    <= winner;
            end else if (state == S_ACCESS && !we_q && !rd_hit) begin
                cnt <= cnt + 3'd1;
            end
        end
    end

    // Read data lands only in the owner's register, on the edge the memory output is due.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m0_rdata <= '0;
            m1_rdata <= '0;
        end else if (state == S_ACCESS && !we_q && rd_hit) begin
            if (owner) begin
                m1_rdata <= mem_rdata;
            end else begin
                m0_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: instance 0 at RD_LATENCY 0, instance 1 at RD_LATENCY 3, each with its own memory.
// Latency and ordering expectations come from a transaction-level model (memory array, last pointer, rdata copies).
// Requests are held until grant and dropped in the grant cycle, as a well-behaved requester would.
module tb_mem_port_arbiter;
    localparam int AW = 9;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [1:0]    req   [2];
    logic [1:0]    we    [2];
    logic [AW-1:0] addr  [2][2];
    logic [15:0]   wdata [2][2];
    logic          m0_gnt [2], m1_gnt [2], m0_done [2], m1_done [2];
    logic [15:0]   m0_rdata [2], m1_rdata [2];
    logic [AW-1:0] mem_addr [2];
    logic [15:0]   mem_wdata [2], mem_rdata [2];
    logic          mem_load [2], busy [2];

    genvar g;
    generate
        for (g = 0; g < 2; g++) begin : g_inst
            mem_port_arbiter #(.ADDR_WIDTH(AW), .RD_LATENCY(g * 3)) dut (
                .clk(clk), .reset(reset),
                .m0_req(req[g][0]), .m0_we(we[g][0]), .m0_addr(addr[g][0]), .m0_wdata(wdata[g][0]),
                .m0_gnt(m0_gnt[g]), .m0_done(m0_done[g]), .m0_rdata(m0_rdata[g]),
                .m1_req(req[g][1]), .m1_we(we[g][1]), .m1_addr(addr[g][1]), .m1_wdata(wdata[g][1]),
                .m1_gnt(m1_gnt[g]), .m1_done(m1_done[g]), .m1_rdata(m1_rdata[g]),
                .mem_addr(mem_addr[g]), .mem_wdata(mem_wdata[g]), .mem_load(mem_load[g]),
                .mem_rdata(mem_rdata[g]), .busy(busy[g])
            );
            // Memory: clears while reset is high, writes on load, read path delayed by g*3 edges.
            logic [15:0] ram [512];
            logic [15:0] d1, d2, d3;
            always @(posedge clk) begin
                if (reset) begin
                    for (int i = 0; i < 512; i++) ram[i] <= '0;
                end else if (mem_load[g]) begin
                    ram[mem_addr[g]] <= mem_wdata[g];
                end
                d1 <= ram[mem_addr[g]];
                d2 <= d1;
                d3 <= d2;
            end
            assign mem_rdata[g] = (g == 0) ? ram[mem_addr[g]] : d3;
        end
    endgenerate

    // Reference model
    logic [15:0] mmem [2][512];
    logic [15:0] mrd  [2][2];
    bit          mlast [2];
    int          done_cyc [2];
    int          nchk = 0;
    int          nerr = 0;

    function automatic int pick(input int k);
        if (req[k] == 2'b11) return mlast[k] ? 0 : 1;
        return req[k][1] ? 1 : 0;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 512; i++) mmem[k][i] = '0;
            mrd[k][0] = '0;
            mrd[k][1] = '0;
            mlast[k] = 1'b1;
            done_cyc[k] = -10;
            req[k] = 2'b00;
        end
    endtask

    // If the bench just watched a done pulse, step through the IDLE cycle that must follow it.
    task automatic to_idle(input int k);
        if (cyc == done_cyc[k]) begin
            @(posedge clk); #1;
            nchk++;
            if ({m0_gnt[k], m1_gnt[k], m0_done[k], m1_done[k], busy[k]} !== 5'b0) begin
                nerr++;
                $display("FAIL idle_after_done k=%0d got %b want 00000", k,
                         {m0_gnt[k], m1_gnt[k], m0_done[k], m1_done[k], busy[k]});
            end
        end
    endtask

    // One complete access by port p on instance k, request already driven.
    task automatic serve(input int k, input int p, input bit keep);
        logic          w;
        logic [AW-1:0] a;
        logic [15:0]   d;
        logic [1:0]    eg;
        int            nacc;
        to_idle(k);
        w  = we[k][p];
        a  = addr[k][p];
        d  = wdata[k][p];
        eg = (p == 1) ? 2'b10 : 2'b01;
        @(posedge clk); #1;
        nchk++;
        if ({m1_gnt[k], m0_gnt[k]} !== eg || busy[k] !== 1'b1) begin
            nerr++;
            $display("FAIL grant k=%0d got gnt=%b busy=%b want gnt=%b busy=1", k, {m1_gnt[k], m0_gnt[k]}, busy[k], eg);
        end
        nchk++;
        if (mem_load[k] !== w || mem_addr[k] !== a || (w && mem_wdata[k] !== d)) begin
            nerr++;
            $display("FAIL mem_drive k=%0d got load=%b addr=%h wdata=%h want load=%b addr=%h wdata=%h",
                     k, mem_load[k], mem_addr[k], mem_wdata[k], w, a, d);
        end
        if (!keep) req[k][p] = 1'b0;
        if (w) mmem[k][a] = d;
        else   mrd[k][p] = mmem[k][a];
        mlast[k] = (p == 1);
        nacc = w ? 1 : ((k == 0) ? 1 : 4);
        for (int i = 1; i < nacc; i++) begin
            @(posedge clk); #1;
            nchk++;
            if ({m0_gnt[k], m1_gnt[k], m0_done[k], m1_done[k], mem_load[k], busy[k]} !== 6'b000001) begin
                nerr++;
                $display("FAIL access_wait k=%0d got %b want 000001", k,
                         {m0_gnt[k], m1_gnt[k], m0_done[k], m1_done[k], mem_load[k], busy[k]});
            end
        end
        @(posedge clk); #1;
        nchk++;
        if ({m1_done[k], m0_done[k]} !== eg || {m1_gnt[k], m0_gnt[k]} !== 2'b00 || mem_load[k] !== 1'b0) begin
            nerr++;
            $display("FAIL done_pulse k=%0d got done=%b gnt=%b load=%b want done=%b gnt=00 load=0",
                     k, {m1_done[k], m0_done[k]}, {m1_gnt[k], m0_gnt[k]}, mem_load[k], eg);
        end
        nchk++;
        if (m0_rdata[k] !== mrd[k][0] || m1_rdata[k] !== mrd[k][1]) begin
            nerr++;
            $display("FAIL rdata k=%0d got %h/%h want %h/%h", k, m0_rdata[k], m1_rdata[k], mrd[k][0], mrd[k][1]);
        end
        done_cyc[k] = cyc;
    endtask

    task automatic set_port(input int k, input int p, input logic w, input logic [AW-1:0] a, input logic [15:0] d);
        we[k][p]    = w;
        addr[k][p]  = a;
        wdata[k][p] = d;
        req[k][p]   = 1'b1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            nchk++;
            if ({m0_gnt[k], m1_gnt[k], m0_done[k], m1_done[k], m0_rdata[k], m1_rdata[k],
                 mem_addr[k], mem_wdata[k], mem_load[k], busy[k]} !== '0) begin
                nerr++;
                $display("FAIL reset_outputs k=%0d got nonzero want all zero", k);
            end
        end
        reset = 1'b0;
        @(posedge clk); #1;
        nchk++;
        if (busy[0] !== 1'b0 || m0_gnt[0] !== 1'b0 || m1_gnt[0] !== 1'b0) begin
            nerr++;
            $display("FAIL idle_no_req got busy=%b gnt=%b%b want 0 00", busy[0], m1_gnt[0], m0_gnt[0]);
        end
    endtask

    task automatic test_write();
        set_port(0, 0, 1'b1, 9'h005, 16'hBEEF);
        serve(0, 0, 0);
    endtask

    task automatic test_read_other();
        set_port(0, 1, 1'b0, 9'h005, 16'h0000);
        serve(0, 1, 0);
    endtask

    task automatic test_tie();
        int ord [4];
        ord = '{0, 1, 0, 1};
        set_port(0, 0, 1'b0, 9'h005, 16'h0);
        set_port(0, 1, 1'b0, 9'h007, 16'h0);
        for (int i = 0; i < 4; i++) serve(0, ord[i], 1);
        req[0] = 2'b00;
    endtask

    task automatic test_latency();
        set_port(1, 0, 1'b1, 9'h0AB, 16'h1234);
        serve(1, 0, 0);
        set_port(1, 0, 1'b0, 9'h0AB, 16'h0);
        serve(1, 0, 0);
    endtask

    task automatic test_reset_mid();
        // Reset during a write's load cycle: strobe must drop without waiting for an edge.
        to_idle(1);
        set_port(1, 0, 1'b1, 9'h010, 16'hA5A5);
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        nchk++;
        if (mem_load[1] !== 1'b0 || m0_gnt[1] !== 1'b0 || busy[1] !== 1'b0) begin
            nerr++;
            $display("FAIL reset_write got load=%b gnt=%b busy=%b want 0 0 0", mem_load[1], m0_gnt[1], busy[1]);
        end
        req[1] = 2'b00;
        @(posedge clk); #1;
        reset = 1'b0;
        model_clear();
        // Reset one cycle after m1's read grant.
        set_port(0, 1, 1'b0, 9'h005, 16'h0);
        @(posedge clk); #1;
        nchk++;
        if (m1_gnt[0] !== 1'b1) begin
            nerr++;
            $display("FAIL mid_grant got m1_gnt=%b want 1", m1_gnt[0]);
        end
        req[0] = 2'b00;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        nchk++;
        if ({m0_gnt[0], m1_gnt[0], m0_done[0], m1_done[0], m0_rdata[0], m1_rdata[0],
             mem_addr[0], mem_wdata[0], mem_load[0], busy[0]} !== '0) begin
            nerr++;
            $display("FAIL reset_mid_outputs got nonzero want all zero");
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            nchk++;
            if (m1_done[0] !== 1'b0) begin
                nerr++;
                $display("FAIL no_done_in_reset got m1_done=%b want 0", m1_done[0]);
            end
        end
        reset = 1'b0;
        model_clear();
        set_port(0, 0, 1'b0, 9'h003, 16'h0);
        set_port(0, 1, 1'b0, 9'h004, 16'h0);
        serve(0, 0, 0);
        serve(0, 1, 0);
    endtask

    task automatic test_back_to_back();
        set_port(0, 1, 1'b1, 9'h1FF, 16'h00FF);
        serve(0, 1, 0);
        set_port(0, 1, 1'b0, 9'h1FF, 16'h0);
        serve(0, 1, 0);
    endtask

    task automatic test_random();
        for (int k = 0; k < 2; k++) begin
            for (int it = 0; it < 25; it++) begin
                logic [1:0] m;
                m = 2'($urandom_range(1, 3));
                for (int p = 0; p < 2; p++) begin
                    if (m[p]) begin
                        logic [AW-1:0] a;
                        a = ($urandom_range(0, 3) == 0) ? 9'h1FF : 9'($urandom_range(0, 15));
                        set_port(k, p, 1'($urandom_range(0, 1)), a, 16'($urandom));
                    end
                end
                while (req[k] != 2'b00) serve(k, pick(k), 0);
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            we[k] = 2'b00;
            for (int p = 0; p < 2; p++) begin
                addr[k][p]  = '0;
                wdata[k][p] = '0;
            end
        end
        model_clear();
        test_reset();
        test_write();
        test_read_other();
        test_tie();
        test_latency();
        test_reset_mid();
        test_back_to_back();
        test_random();
        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", nchk, nerr);
        $finish;
    end
endmodule
